// File: rtl/duty_sched_pkg.sv
// Shared types, constants and the drive-request mapping for the duty sequencer.
package duty_sched_pkg;

  typedef logic [10:0] duty_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam duty_t MID_DUTY = 11'h400;

  // Clamp the signed request to [-1024,+1023] and centre it on MID_DUTY.
  // After clamping, the biased sum lies in 0..2047, so the 11-bit result never wraps.
  function automatic duty_t sat_drv(input logic signed [11:0] drv);
    logic [11:0] biased;
    duty_t       result;
    biased = 12'(drv) + 12'h400;
    if (drv > 12'sd1023) begin
      result = 11'h7FF;
    end else if (drv < -12'sd1024) begin
      result = 11'h000;
    end else begin
      result = biased[10:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/duty_sched_if.sv
// Signal bundle between the balance controller / PWM generator side and duty_sched.
interface duty_sched_if;
  import duty_sched_pkg::*;

  logic               en;
  logic signed [11:0] drv_req;
  logic               pwm_synch;
  logic               ovr_I_blank;
  logic               ovr_I;
  logic               fault_clr;
  duty_t              duty;
  logic               pwm_en;
  logic               fault;
  logic               upd;

  // Controller / environment side.
  modport master (
    output en, drv_req, pwm_synch, ovr_I_blank, ovr_I, fault_clr,
    input  duty, pwm_en, fault, upd
  );

  // Sequencer side.
  modport slave (
    input  en, drv_req, pwm_synch, ovr_I_blank, ovr_I, fault_clr,
    output duty, pwm_en, fault, upd
  );
endinterface

// File: rtl/duty_sched_oc_monitor.sv
// Over-current period counter: counts consecutive PWM periods that saw an
// unblanked over-current while the bridge was enabled, and flags the trip.
module duty_sched_oc_monitor #(
  parameter int unsigned OVR_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_synch_i,
  input  logic oc_raw_i,
  input  logic oc_blank_i,
  input  logic pwm_en_i,
  input  logic clr_i,
  output logic oc_trip_o
);

  logic       oc_seen_q, oc_seen_d;
  logic [3:0] oc_cnt_q, oc_cnt_d;
  logic [3:0] cnt_inc;
  logic       hit_now;

  // Next-state of the period flag and counter; the trip is combinational so the
  // top can move to FAULT on the very edge that closes the offending period.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    hit_now   = oc_raw_i & ~oc_blank_i & pwm_en_i;
    cnt_inc   = (oc_cnt_q == 4'hF) ? 4'hF : oc_cnt_q + 4'd1;
    oc_seen_d = oc_seen_q | hit_now;
    oc_cnt_d  = oc_cnt_q;
    oc_trip_o = 1'b0;
    if (pwm_synch_i) begin
      // A hit on the synch cycle itself belongs to the period now closing.
      if (oc_seen_q | hit_now) begin
        oc_cnt_d  = cnt_inc;
        oc_trip_o = (cnt_inc == 4'(OVR_LIMIT));
      end else begin
        oc_cnt_d = 4'd0;
      end
      oc_seen_d = 1'b0;
    end
    if (clr_i) begin
      oc_seen_d = 1'b0;
      oc_cnt_d  = 4'd0;
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      oc_seen_q <= 1'b0;
      oc_cnt_q  <= 4'd0;
    end else begin
      oc_seen_q <= oc_seen_d;
      oc_cnt_q  <= oc_cnt_d;
    end
  end

endmodule

// File: rtl/duty_sched.sv
// Duty sequencer for one motor channel: maps the drive request to a centred
// duty, slew-limits it at PWM period boundaries and latches over-current faults.
module duty_sched
  import duty_sched_pkg::*;
#(
  parameter duty_t       SLEW_STEP = 11'd16,
  parameter int unsigned OVR_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  duty_sched_if.slave  bus
);

  state_t state_q, state_d;
  duty_t  duty_q, duty_d;
  logic   pwm_en_q, pwm_en_d;
  logic   fault_q, fault_d;
  logic   upd_q, upd_d;

  duty_t              target;
  duty_t              step;
  duty_t              slew_duty;
  logic signed [11:0] diff;
  logic signed [11:0] step_s;
  logic               oc_trip;
  logic               oc_clr;

  duty_sched_oc_monitor #(
    .OVR_LIMIT (OVR_LIMIT)
  ) u_oc_monitor (
    .clk         (clk),
    .rst         (rst),
    .pwm_synch_i (bus.pwm_synch),
    .oc_raw_i    (bus.ovr_I),
    .oc_blank_i  (bus.ovr_I_blank),
    .pwm_en_i    (pwm_en_q),
    .clr_i       (oc_clr),
    .oc_trip_o   (oc_trip)
  );

  // Slew datapath: move the duty toward the target by at most one step.
  always_comb begin
    target = sat_drv(bus.drv_req);
    step   = (state_q == RAMP) ? (SLEW_STEP >> 2) : SLEW_STEP;
    step_s = $signed({1'b0, step});
    diff   = $signed({1'b0, target}) - $signed({1'b0, duty_q});
    if (diff > step_s) begin
      slew_duty = duty_q + step;
    end else if (diff < -step_s) begin
      slew_duty = duty_q - step;
    end else begin
      slew_duty = target;
    end
  end

  // Next-state and registered-output logic; the over-current trip outranks both
  // the slew update and a falling enable in the same cycle.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        duty_d = MID_DUTY;
        if (bus.en) state_d = RAMP;
      end
      RAMP, RUN: begin
        if (oc_trip) begin
          state_d = FAULT;
          duty_d  = MID_DUTY;
        end else if (!bus.en) begin
          state_d = IDLE;
          duty_d  = MID_DUTY;
        end else if (bus.pwm_synch) begin
          duty_d = slew_duty;
          upd_d  = (slew_duty != duty_q);
          if (state_q == RAMP && slew_duty == target) state_d = RUN;
        end
      end
      FAULT: begin
        duty_d = MID_DUTY;
        if (bus.fault_clr && !bus.en) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        duty_d  = MID_DUTY;
      end
    endcase
    pwm_en_d = (state_d == RAMP) || (state_d == RUN);
    fault_d  = (state_d == FAULT);
    oc_clr   = (state_d != state_q) && ((state_d == IDLE) || (state_d == FAULT));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= MID_DUTY;
      pwm_en_q <= 1'b0;
      fault_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      pwm_en_q <= pwm_en_d;
      fault_q  <= fault_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.duty   = duty_q;
  assign bus.pwm_en = pwm_en_q;
  assign bus.fault  = fault_q;
  assign bus.upd    = upd_q;

endmodule
